// File: rtl/oneshot_rate_monitor.sv
// Per-channel pulse-rate monitor: counts one-shot pulses over back-to-back gate
// windows and snapshots the saturating counts for valid/ack readout.
module oneshot_rate_monitor #(
  parameter int NCH       = 8,
  parameter int CNT_BITS  = 16,
  parameter int GATE_BITS = 24
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable_i,
  input  logic [GATE_BITS-1:0]    gate_len_i,
  input  logic [NCH-1:0]          pulse_i,
  input  logic                    ack_i,
  output logic [NCH*CNT_BITS-1:0] rate_o,
  output logic [NCH-1:0]          sat_o,
  output logic                    valid_o,
  output logic                    overrun_o
);

  typedef enum logic {IDLE, COUNT} state_t;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  state_t                          state_q, state_d;
  logic [GATE_BITS-1:0]            timer_q, timer_d;
  logic [NCH-1:0][CNT_BITS-1:0]    cnt_q, cnt_d, fin_cnt;
  logic [NCH-1:0]                  wsat_q, wsat_d, fin_sat;
  logic [NCH-1:0][CNT_BITS-1:0]    rate_q, rate_d;
  logic [NCH-1:0]                  sat_q, sat_d;
  logic                            valid_q, valid_d;
  logic                            overrun_q, overrun_d;

  logic terminal;
  logic load_timer;
  logic count_en;
  logic snap;
  logic ack_acc;

  assign terminal = (timer_q == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Both states follow enable_i: a terminal cycle either chains the next
  // window or stops, and a dropped enable abandons a running window.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = enable_i ? COUNT : IDLE;
      COUNT:   state_d = enable_i ? COUNT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    load_timer = 1'b0;
    count_en   = 1'b0;
    snap       = 1'b0;
    case (state_q)
      IDLE:  load_timer = enable_i;
      COUNT: begin
        snap       = terminal;
        load_timer = terminal & enable_i;
        count_en   = ~terminal & enable_i;
      end
      default: ;
    endcase
  end

  // Final per-window values including the current cycle's pulses.
  always_comb begin
    fin_cnt = cnt_q;
    fin_sat = wsat_q;
    for (int k = 0; k < NCH; k++) begin
      if (pulse_i[k]) begin
        if (cnt_q[k] == CNT_MAX) fin_sat[k] = 1'b1;
        else                     fin_cnt[k] = cnt_q[k] + CNT_BITS'(1);
      end
    end
  end

  assign ack_acc = valid_q & ack_i;

  always_comb begin
    timer_d   = timer_q;
    cnt_d     = '0;
    wsat_d    = '0;
    rate_d    = rate_q;
    sat_d     = sat_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (load_timer)
      timer_d = (gate_len_i == '0) ? '0 : gate_len_i - GATE_BITS'(1);
    else if (count_en)
      timer_d = timer_q - GATE_BITS'(1);

    if (count_en) begin
      cnt_d  = fin_cnt;
      wsat_d = fin_sat;
    end

    if (snap) begin
      rate_d  = fin_cnt;
      sat_d   = fin_sat;
      valid_d = 1'b1;
    end else if (ack_acc) begin
      valid_d = 1'b0;
    end

    // A snapshot landing on unread data is an overrun unless acked this cycle.
    if (snap && valid_q && !ack_i) overrun_d = 1'b1;
    else if (ack_acc)              overrun_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_q   <= '0;
      cnt_q     <= '0;
      wsat_q    <= '0;
      rate_q    <= '0;
      sat_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      wsat_q    <= wsat_d;
      rate_q    <= rate_d;
      sat_q     <= sat_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign rate_o    = rate_q;
  assign sat_o     = sat_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: doc/oneshot_rate_monitor.md
Name: oneshot_rate_monitor

Overview:
- Per-channel rate monitor sitting directly downstream of the S-bit one-shot stage.
- Counts the 1-clock one-shot pulses on NCH channels over a programmable gate window.
- At the end of each window, snapshots all counts into an output register with sticky saturation flags, for slow-control readout through a valid/ack handshake.
- Windows run back-to-back with no dead cycle while enabled.

Parameters:
- NCH, 8, number of monitored channels (one-shot outputs).
- CNT_BITS, 16, width of each per-channel counter; counters saturate at 2^CNT_BITS-1.
- GATE_BITS, 24, width of the gate-length input.

Ports:
- clock  input  1  single logic clock (same clock as the one-shot output FFs).
- reset  input  1  asynchronous, active-high reset.
- enable_i  input  1  run windows while high; dropping it abandons the current window.
- gate_len_i  input  GATE_BITS  window length in clock cycles; 0 is treated as 1.
- pulse_i  input  NCH  one-shot pulses, one bit per channel.
- ack_i  input  1  readout acknowledge.
- rate_o  output  NCH*CNT_BITS  snapshot counts; channel k occupies bits [k*CNT_BITS +: CNT_BITS].
- sat_o  output  NCH  per-channel flag: count saturated during the snapshotted window.
- valid_o  output  1  snapshot available.
- overrun_o  output  1  a snapshot was overwritten before it was acknowledged.

Behaviour:
- Reset (async assert, clocked release): state IDLE; counters, timer, rate_o, sat_o, valid_o and overrun_o all 0.
- States: IDLE and COUNT.
- IDLE:
  - Counters are held at 0.
  - If enable_i=1, go to COUNT next cycle and load timer = max(gate_len_i,1)-1.
  - gate_len_i is sampled only at window load, so mid-window changes have no effect.
- COUNT, every cycle:
  - For each channel with pulse_i[k]=1, counter[k] increments by 1.
  - A counter at 2^CNT_BITS-1 holds its value and sets its per-window sat flag.
  - The timer decrements.
- Terminal cycle (timer==0 in COUNT):
  - A pulse arriving in this cycle is included in the result.
  - On the next edge: rate_o[k] <= final count (counter+pulse, saturating); sat_o <= final sat flags.
  - On the same edge: counters and window sat flags are cleared.
  - If enable_i=1, reload the timer from gate_len_i and stay in COUNT (no dead cycle; a pulse in the first cycle of the new window counts as 1). Otherwise go to IDLE.
- Window length: exactly gate_len_i cycles. With gate_len_i=1, every COUNT cycle is a terminal cycle.
- enable_i=0 during a non-terminal COUNT cycle: the window is abandoned. Go to IDLE, clear counters; no snapshot is taken and rate_o, sat_o and valid_o are unchanged.
- Snapshot latency: valid_o rises on the same edge that updates rate_o, i.e. 1 cycle after the terminal cycle.
- Handshake:
  - valid_o stays high until ack_i=1 is sampled while valid_o=1, then clears on the next edge.
  - ack_i while valid_o=0 is ignored.
  - rate_o and sat_o hold their values after ack.
- Snapshot landing while valid_o=1:
  - ack_i=0: rate_o/sat_o are overwritten, valid_o stays 1, overrun_o is set.
  - ack_i=1 in the same cycle: the new snapshot wins, valid_o stays 1, overrun_o is not set (the old data was consumed).
- overrun_o is sticky and clears when an ack is accepted without a concurrent overrun.
- Reset mid-window or mid-handshake: immediate return to reset values; the partial window is discarded.
- Width rules: counters are CNT_BITS unsigned; the timer is GATE_BITS unsigned; no arithmetic wraps anywhere.

Test Plan:
1. gate_len=10, enable=1, pulses on ch0 at cycles 0,3,9 of the window and ch7 every cycle -> after the 10th cycle: rate ch0=3, ch7=10, others 0, valid_o=1 one cycle later, sat_o=0.
2. CNT_BITS=4, gate_len=40, ch2 pulsing continuously -> rate ch2=15, sat_o[2]=1; the next window with no pulses yields 0 and sat_o[2]=0.
3. Back-to-back windows with gate_len=5, ch1 pulsing every cycle, ack_i pulsed once after each valid -> every snapshot equals 5 with no lost or double-counted pulse at the boundaries; overrun_o=0.
4. Two windows complete without ack -> second snapshot visible and overrun_o=1; ack -> valid_o=0 and overrun_o=0 next cycle. Repeat with ack coincident with the second snapshot -> valid_o stays 1, overrun_o=0.
5. enable_i dropped mid-window after 4 pulses on ch3 -> no valid_o, rate_o unchanged; re-enable -> new full window counts only the new pulses.
6. Assert reset mid-window while valid_o=1 -> all outputs 0 immediately; gate_len=0 after release -> 1-cycle windows, snapshot every cycle.
